// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: move tick from the 100 Hz divider, ball motion, bounces, scoring, serve/game-over.
// Optional PONG_SPEEDUP_EN: every 4 paddle hits the step divisor shrinks by 1 (floor 1), restored in IDLE.
module pong_ball_ctrl #(
   parameter int X_MAX      = 79,
   parameter int Y_MAX      = 59,
   parameter int X_W        = 7,
   parameter int Y_W        = 6,
   parameter int PADDLE_H   = 8,
   parameter int STEP_DIV   = 4,
   parameter int HOLD_TICKS = 50,
   parameter int WIN_SCORE  = 9
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           slow_clk,
   input  logic           serve,
   input  logic [Y_W-1:0] paddle_l_y,
   input  logic [Y_W-1:0] paddle_r_y,
   output logic [X_W-1:0] ball_x,
   output logic [Y_W-1:0] ball_y,
   output logic [3:0]     score_l,
   output logic [3:0]     score_r,
   output logic [1:0]     state,
   output logic           point_l,
   output logic           point_r
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   localparam logic [X_W-1:0] X_CTR  = X_W'(X_MAX / 2);
   localparam logic [X_W-1:0] X_LCHK = X_W'(1);
   localparam logic [X_W-1:0] X_LHIT = X_W'(2);
   localparam logic [X_W-1:0] X_RCHK = X_W'(X_MAX - 1);
   localparam logic [X_W-1:0] X_RHIT = X_W'(X_MAX - 2);
   localparam logic [Y_W-1:0] Y_CTR  = Y_W'(Y_MAX / 2);
   localparam logic [Y_W-1:0] Y_BOT  = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0] Y_BOT1 = Y_W'(Y_MAX - 1);
   localparam logic [Y_W:0]   SPAN   = (Y_W + 1)'(PADDLE_H - 1);
   localparam logic [3:0]     WIN    = 4'(WIN_SCORE);
   localparam logic [3:0]     DIV0   = 4'(STEP_DIV);
   localparam logic [HW-1:0]  HLAST  = HW'(HOLD_TICKS - 1);

   state_t         st, st_n;
   logic           slow_clk_d, serve_d, tick, serve_p;
   logic           dx_left, dx_left_n, dy_up, dy_up_n;
   logic [X_W-1:0] x_n;
   logic [Y_W-1:0] y_n, y_mv;
   logic           up_mv;
   logic [3:0]     score_l_n, score_r_n, step_cnt, step_n;
   logic           point_l_n, point_r_n;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic           hit_l, hit_r, paddle_hit, to_idle;

`ifdef PONG_SPEEDUP_EN
   logic [3:0] step_div, step_div_n;
   logic [1:0] hit_cnt, hit_cnt_n;
`else
   logic [3:0] step_div;
   assign step_div = DIV0;
`endif

   assign tick    = slow_clk & ~slow_clk_d;
   assign serve_p = serve & ~serve_d;
   assign state   = st;

   // Paddle span compared one bit wider so a paddle near the bottom cannot wrap.
   assign hit_l = ({1'b0, ball_y} >= {1'b0, paddle_l_y}) && ({1'b0, ball_y} <= {1'b0, paddle_l_y} + SPAN);
   assign hit_r = ({1'b0, ball_y} >= {1'b0, paddle_r_y}) && ({1'b0, ball_y} <= {1'b0, paddle_r_y} + SPAN);

   always_comb begin
      y_mv  = ball_y + Y_W'(1);
      up_mv = 1'b0;
      if (!dy_up && ball_y == Y_BOT) begin
         y_mv  = Y_BOT1;
         up_mv = 1'b1;
      end else if (dy_up && ball_y == '0) begin
         y_mv  = Y_W'(1);
         up_mv = 1'b0;
      end else if (dy_up) begin
         y_mv  = ball_y - Y_W'(1);
         up_mv = 1'b1;
      end
   end

   always_comb begin
      // NOTE: every next-state variable gets a default before the case, so no path can infer a latch.
      st_n       = st;
      x_n        = ball_x;
      y_n        = ball_y;
      dx_left_n  = dx_left;
      dy_up_n    = dy_up;
      score_l_n  = score_l;
      score_r_n  = score_r;
      point_l_n  = 1'b0;
      point_r_n  = 1'b0;
      step_n     = step_cnt;
      hold_n     = hold_cnt;
      paddle_hit = 1'b0;
      to_idle    = 1'b0;

      case (st)
         IDLE: begin
            x_n = X_CTR;
            y_n = Y_CTR;
            if (serve_p) begin
               st_n   = PLAY;
               step_n = '0;
            end
         end
         PLAY: begin
            if (tick) begin
               if (step_cnt != step_div - 4'd1) begin
                  step_n = step_cnt + 4'd1;
               end else begin
                  step_n = '0;
                  if (dx_left && ball_x == X_LCHK) begin
                     if (hit_l) begin
                        dx_left_n  = 1'b0;
                        x_n        = X_LHIT;
                        y_n        = y_mv;
                        dy_up_n    = up_mv;
                        paddle_hit = 1'b1;
                     end else begin
                        score_r_n = score_r + 4'd1;
                        point_r_n = 1'b1;
                        hold_n    = '0;
                        st_n      = POINT;
                        dx_left_n = 1'b0;
                        dy_up_n   = 1'b0;
                     end
                  end else if (!dx_left && ball_x == X_RCHK) begin
                     if (hit_r) begin
                        dx_left_n  = 1'b1;
                        x_n        = X_RHIT;
                        y_n        = y_mv;
                        dy_up_n    = up_mv;
                        paddle_hit = 1'b1;
                     end else begin
                        score_l_n = score_l + 4'd1;
                        point_l_n = 1'b1;
                        hold_n    = '0;
                        st_n      = POINT;
                        dx_left_n = 1'b1;
                        dy_up_n   = 1'b0;
                     end
                  end else begin
                     x_n     = dx_left ? ball_x - X_W'(1) : ball_x + X_W'(1);
                     y_n     = y_mv;
                     dy_up_n = up_mv;
                  end
               end
            end
         end
         POINT: begin
            if (score_l == WIN || score_r == WIN) begin
               st_n = OVER;
            end else if (tick) begin
               if (hold_cnt == HLAST) begin
                  st_n    = IDLE;
                  x_n     = X_CTR;
                  y_n     = Y_CTR;
                  to_idle = 1'b1;
               end else begin
                  hold_n = hold_cnt + HW'(1);
               end
            end
         end
         OVER: begin
            if (serve_p) begin
               score_l_n = '0;
               score_r_n = '0;
               x_n       = X_CTR;
               y_n       = Y_CTR;
               dx_left_n = 1'b0;
               dy_up_n   = 1'b0;
               st_n      = IDLE;
               to_idle   = 1'b1;
            end
         end
         default: st_n = IDLE;
      endcase
   end

`ifdef PONG_SPEEDUP_EN
   always_comb begin
      step_div_n = step_div;
      hit_cnt_n  = hit_cnt;
      if (to_idle) begin
         step_div_n = DIV0;
         hit_cnt_n  = '0;
      end else if (paddle_hit) begin
         hit_cnt_n = hit_cnt + 2'd1;
         if (hit_cnt == 2'd3 && step_div > 4'd1) step_div_n = step_div - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_div <= DIV0;
         hit_cnt  <= '0;
      end else begin
         step_div <= step_div_n;
         hit_cnt  <= hit_cnt_n;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         st         <= IDLE;
         slow_clk_d <= 1'b0;
         serve_d    <= 1'b0;
         ball_x     <= X_CTR;
         ball_y     <= Y_CTR;
         dx_left    <= 1'b0;
         dy_up      <= 1'b0;
         score_l    <= '0;
         score_r    <= '0;
         point_l    <= 1'b0;
         point_r    <= 1'b0;
         step_cnt   <= '0;
         hold_cnt   <= '0;
      end else begin
         st         <= st_n;
         slow_clk_d <= slow_clk;
         serve_d    <= serve;
         ball_x     <= x_n;
         ball_y     <= y_n;
         dx_left    <= dx_left_n;
         dy_up      <= dy_up_n;
         score_l    <= score_l_n;
         score_r    <= score_r_n;
         point_l    <= point_l_n;
         point_r    <= point_r_n;
         step_cnt   <= step_n;
         hold_cnt   <= hold_n;
      end
   end

   logic unused_ok;
   assign unused_ok = paddle_hit | to_idle;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scoreboard bench for pong_ball_ctrl on a 15x11 field: expected snapshots are queued with each stimulus.
module tb_pong_ball_ctrl;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] sl;
      logic [3:0] sr;
      logic [1:0] st;
      logic       pl;
      logic       pr;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       slow_clk = 1'b0;
   logic       serve = 1'b0;
   logic [3:0] paddle_l_y = 4'd0;
   logic [3:0] paddle_r_y = 4'd0;
   logic [3:0] ball_x, ball_y, score_l, score_r;
   logic [1:0] state;
   logic       point_l, point_r;

   int   errors = 0;
   int   checks = 0;
   obs_t exp_q[$];

   pong_ball_ctrl #(
      .X_MAX(15), .Y_MAX(11), .X_W(4), .Y_W(4), .PADDLE_H(4),
      .STEP_DIV(1), .HOLD_TICKS(2), .WIN_SCORE(2)
   ) dut (
      .clk(clk), .rst(rst), .slow_clk(slow_clk), .serve(serve),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
      .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
      .state(state), .point_l(point_l), .point_r(point_r)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (4) @(negedge clk);
         slow_clk = ~slow_clk;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   function automatic obs_t mk(int x, int y, int sl, int sr, int st, int pl, int pr);
      obs_t o;
      o.x  = 4'(x);
      o.y  = 4'(y);
      o.sl = 4'(sl);
      o.sr = 4'(sr);
      o.st = 2'(st);
      o.pl = 1'(pl);
      o.pr = 1'(pr);
      return o;
   endfunction

   function automatic obs_t snap();
      obs_t o;
      o.x  = ball_x;
      o.y  = ball_y;
      o.sl = score_l;
      o.sr = score_r;
      o.st = state;
      o.pl = point_l;
      o.pr = point_r;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("(x=%0d y=%0d sl=%0d sr=%0d st=%0d pl=%b pr=%b)", o.x, o.y, o.sl, o.sr, o.st, o.pl, o.pr);
   endfunction

   // One move tick: wait for the slow clock to rise, let the DUT see it, sample just after the edge.
   task automatic do_tick();
      @(posedge slow_clk);
      @(posedge clk);
      #1;
   endtask

   // Serve pulse placed while slow_clk is low so it never shares a cycle with a tick.
   task automatic press_serve();
      @(negedge slow_clk);
      @(negedge clk);
      serve = 1'b1;
      @(posedge clk);
      #1;
      serve = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      #12;
      exp_q.push_back(mk(7, 5, 0, 0, 0, 0, 0));
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_hold: got %s expected %s", fmt(got), fmt(exp)); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(7, 5, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         do_tick();
         got = snap(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL idle_tick%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      end
   endtask

   task automatic test_serve_and_wall();
      obs_t got, exp;
      exp_q.push_back(mk(7, 5, 0, 0, 1, 0, 0));
      press_serve();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL serve_play: got %s expected %s", fmt(got), fmt(exp)); end
      for (int i = 1; i <= 6; i++) exp_q.push_back(mk(7 + i, 5 + i, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(14, 10, 0, 0, 1, 0, 0));
      for (int i = 1; i <= 7; i++) begin
         do_tick();
         got = snap(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL move_tick%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      end
   endtask

   task automatic test_paddle_hit();
      obs_t got, exp;
      paddle_r_y = 4'd8;
      exp_q.push_back(mk(13, 9, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(12, 8, 0, 0, 1, 0, 0));
      for (int i = 0; i < 2; i++) begin
         do_tick();
         got = snap(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL right_hit%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      end
   endtask

   task automatic test_point();
      obs_t got, exp;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      paddle_r_y = 4'd8;
      press_serve();
      repeat (7) do_tick();
      paddle_r_y = 4'd0;
      exp_q.push_back(mk(14, 10, 1, 0, 2, 1, 0));
      do_tick();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL miss_point: got %s expected %s", fmt(got), fmt(exp)); end
      exp_q.push_back(mk(14, 10, 1, 0, 2, 0, 0));
      @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL pulse_end: got %s expected %s", fmt(got), fmt(exp)); end
      exp_q.push_back(mk(14, 10, 1, 0, 2, 0, 0));
      exp_q.push_back(mk(7, 5, 1, 0, 0, 0, 0));
      for (int i = 0; i < 2; i++) begin
         do_tick();
         got = snap(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL hold_tick%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      end
      exp_q.push_back(mk(7, 5, 1, 0, 1, 0, 0));
      press_serve();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reserve: got %s expected %s", fmt(got), fmt(exp)); end
      exp_q.push_back(mk(6, 6, 1, 0, 1, 0, 0));
      do_tick();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL serve_dir_left: got %s expected %s", fmt(got), fmt(exp)); end
   endtask

   task automatic test_game_over();
      obs_t got, exp;
      paddle_l_y = 4'd8;
      paddle_r_y = 4'd8;
      for (int i = 1; i <= 5; i++) exp_q.push_back(mk(6 - i, 6 + i, 1, 0, 1, 0, 0));
      exp_q.push_back(mk(2, 10, 1, 0, 1, 0, 0));
      for (int i = 1; i <= 10; i++) exp_q.push_back(mk(2 + i, 10 - i, 1, 0, 1, 0, 0));
      exp_q.push_back(mk(13, 1, 1, 0, 1, 0, 0));
      exp_q.push_back(mk(14, 2, 1, 0, 1, 0, 0));
      exp_q.push_back(mk(14, 2, 2, 0, 2, 1, 0));
      for (int i = 1; i <= 19; i++) begin
         do_tick();
         got = snap(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL rally_tick%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      end
      exp_q.push_back(mk(14, 2, 2, 0, 3, 0, 0));
      @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL enter_over: got %s expected %s", fmt(got), fmt(exp)); end
      exp_q.push_back(mk(14, 2, 2, 0, 3, 0, 0));
      do_tick();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL over_frozen: got %s expected %s", fmt(got), fmt(exp)); end
      exp_q.push_back(mk(7, 5, 0, 0, 0, 0, 0));
      press_serve();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL over_serve: got %s expected %s", fmt(got), fmt(exp)); end
   endtask

   task automatic test_reset_mid_play();
      obs_t got, exp;
      exp_q.push_back(mk(7, 5, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(8, 6, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(9, 7, 0, 0, 1, 0, 0));
      press_serve();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL play_again: got %s expected %s", fmt(got), fmt(exp)); end
      for (int i = 0; i < 2; i++) begin
         do_tick();
         got = snap(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL pre_rst_tick%0d: got %s expected %s", i, fmt(got), fmt(exp)); end
      end
      #2;
      rst = 1'b1;
      exp_q.push_back(mk(7, 5, 0, 0, 0, 0, 0));
      #1;
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL async_rst: got %s expected %s", fmt(got), fmt(exp)); end
      exp_q.push_back(mk(7, 5, 0, 0, 0, 0, 0));
      do_tick();
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_held: got %s expected %s", fmt(got), fmt(exp)); end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk(7, 5, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_release: got %s expected %s", fmt(got), fmt(exp)); end
   endtask

   initial begin
      test_reset();
      test_serve_and_wall();
      test_paddle_hit();
      test_point();
      test_game_over();
      test_reset_mid_play();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
